// File: rtl/tx_strobe_sched_if.sv
// ----------------------------------------------------------------------------
// tx_strobe_sched_if
//
// Purpose: bundles the FIFO handshake and the rate strobes that run between
// the TX strobe scheduler and the interpolation datapath / TX FIFO.
//
// Signals:
//   fifo_empty          TX FIFO has no I/Q sample available (FIFO -> scheduler)
//   sample_strobe       CIC output strobe, DAC rate
//   hb_strobe           halfband output strobe / CIC input strobe
//   interpolator_strobe halfband input strobe; one new sample consumed
//   fifo_rd             FIFO pop
//   zero_stuff          datapath must present 0 on its I/Q inputs this cycle
//
// Modports:
//   master  scheduler side (drives strobes, observes fifo_empty)
//   slave   datapath/FIFO side
// ----------------------------------------------------------------------------
interface tx_strobe_sched_if;
    logic fifo_empty;
    logic sample_strobe;
    logic hb_strobe;
    logic interpolator_strobe;
    logic fifo_rd;
    logic zero_stuff;

    modport master (
        input  fifo_empty,
        output sample_strobe,
        output hb_strobe,
        output interpolator_strobe,
        output fifo_rd,
        output zero_stuff
    );

    modport slave (
        output fifo_empty,
        input  sample_strobe,
        input  hb_strobe,
        input  interpolator_strobe,
        input  fifo_rd,
        input  zero_stuff
    );
endinterface

// File: rtl/tx_strobe_sched.sv
// ----------------------------------------------------------------------------
// tx_strobe_sched
//
// Purpose: strobe scheduler and sample-fetch controller for the TX
// interpolation chain (halfband x2 followed by CIC x rate). One input sample
// is consumed every 2*rate clocks. Start-up waits for TX FIFO data, rate
// changes land only on input-sample boundaries, and FIFO underruns are
// flagged, counted and answered with zero samples instead of stalling.
//
// Ports:
//   i_clk             master DSP clock (DAC sample rate)
//   i_rst_n           asynchronous active-low reset
//   i_enable          TX chain enable; low returns to IDLE
//   i_interp_rate[8]  CIC interpolation factor (0 treated as 1)
//   i_rate_load       single-cycle pulse capturing i_interp_rate
//   i_underrun_clr    single-cycle pulse clearing underrun flag and count
//   io_strb           strobe / FIFO handshake bundle (master side)
//   o_underrun        sticky underrun flag
//   o_underrun_count  saturating underrun counter
//   o_active          high while in RUN
//   o_debug[8]        {state[1:0], hb_phase, pend, cic_cnt[3:0]}
// ----------------------------------------------------------------------------
module tx_strobe_sched (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_enable,
    input  logic [7:0]               i_interp_rate,
    input  logic                     i_rate_load,
    input  logic                     i_underrun_clr,
    tx_strobe_sched_if.master        io_strb,
    output logic                     o_underrun,
    output logic [15:0]              o_underrun_count,
    output logic                     o_active,
    output logic [7:0]               o_debug
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRIME = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    logic [1:0]  r_state;
    logic [7:0]  r_rate_q;
    logic [7:0]  r_rate_pend;
    logic        r_pend;
    logic [7:0]  r_cic_cnt;
    logic        r_hb_phase;
    logic        r_underrun;
    logic [15:0] r_underrun_count;

    logic        w_run;
    logic        w_hb;
    logic        w_interp;
    logic        w_zero_stuff;
    logic        w_boundary;
    logic [7:0]  w_load_rate;

    // Strobes are pure decodes of registered state, so they drop at once
    // when reset clears the state.
    assign w_run        = (r_state == ST_RUN);
    assign w_hb         = w_run && (r_cic_cnt == (r_rate_q - 8'd1));
    assign w_interp     = w_hb && r_hb_phase;
    assign w_zero_stuff = w_interp && io_strb.fifo_empty;

    // A pending rate may be applied whenever the schedule is not running,
    // or on an input-sample boundary while it is.
    assign w_boundary   = !w_run || w_interp;
    assign w_load_rate  = (i_interp_rate == 8'd0) ? 8'd1 : i_interp_rate;

    assign io_strb.sample_strobe       = w_run;
    assign io_strb.hb_strobe           = w_hb;
    assign io_strb.interpolator_strobe = w_interp;
    assign io_strb.fifo_rd             = w_interp && !io_strb.fifo_empty;
    assign io_strb.zero_stuff          = w_zero_stuff;

    assign o_underrun       = r_underrun;
    assign o_underrun_count = r_underrun_count;
    assign o_active         = w_run;
    assign o_debug          = {r_state, r_hb_phase, r_pend, r_cic_cnt[3:0]};

    // ------------------------------------------------------------------
    // State machine and strobe counters
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_cic_cnt  <= 8'd0;
            r_hb_phase <= 1'b0;
        end else if (!i_enable) begin
            r_state    <= ST_IDLE;
            r_cic_cnt  <= 8'd0;
            r_hb_phase <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state    <= ST_PRIME;
                    r_cic_cnt  <= 8'd0;
                    r_hb_phase <= 1'b0;
                end
                ST_PRIME: begin
                    // Counters held at zero so RUN starts at cycle 0.
                    r_cic_cnt  <= 8'd0;
                    r_hb_phase <= 1'b0;
                    if (!io_strb.fifo_empty) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_hb) begin
                        r_cic_cnt  <= 8'd0;
                        r_hb_phase <= !r_hb_phase;
                    end else begin
                        r_cic_cnt  <= r_cic_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_cic_cnt  <= 8'd0;
                    r_hb_phase <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Rate handling. Later statements take priority: a fresh load always
    // survives (last load wins), and a load coinciding with a sample
    // boundary goes straight into the effective rate.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rate_q    <= 8'd1;
            r_rate_pend <= 8'd1;
            r_pend      <= 1'b0;
        end else begin
            if (r_pend && w_boundary) begin
                r_rate_q <= r_rate_pend;
                r_pend   <= 1'b0;
            end
            if (!i_enable) begin
                r_pend <= 1'b0;
            end
            if (i_rate_load) begin
                r_rate_pend <= w_load_rate;
                if (w_interp) begin
                    r_rate_q <= w_load_rate;
                    r_pend   <= 1'b0;
                end else begin
                    r_pend   <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Underrun flag and saturating counter. A clear coinciding with a new
    // underrun leaves exactly that one underrun recorded.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_underrun       <= 1'b0;
            r_underrun_count <= 16'd0;
        end else if (i_underrun_clr) begin
            r_underrun       <= w_zero_stuff;
            r_underrun_count <= w_zero_stuff ? 16'd1 : 16'd0;
        end else if (w_zero_stuff) begin
            r_underrun <= 1'b1;
            if (r_underrun_count != 16'hFFFF) begin
                r_underrun_count <= r_underrun_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_tx_strobe_sched.sv
// ----------------------------------------------------------------------------
// tb_tx_strobe_sched
//
// Scoreboard bench for tx_strobe_sched. Each driven cycle pushes the expected
// {sample, active, hb, interp, fifo_rd, zero_stuff} vector derived from the
// documented schedule (hb at RUN cycle k when (k+1)%R==0, interp when
// (k+1)%(2R)==0); a monitor pops and compares on the falling edge. Scenario
// tasks add inline checks of underrun status, debug and reset behaviour.
// ----------------------------------------------------------------------------
module tb_tx_strobe_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [7:0]  interp_rate;
    logic        rate_load;
    logic        underrun_clr;
    logic        underrun;
    logic [15:0] underrun_count;
    logic        active;
    logic [7:0]  debug;

    int n_err = 0;
    int n_chk = 0;

    logic [5:0] exp_q[$];
    logic [5:0] mon_exp;
    logic [5:0] mon_act;

    always #5 clk = ~clk;

    tx_strobe_sched_if u_if();

    tx_strobe_sched dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_enable         (enable),
        .i_interp_rate    (interp_rate),
        .i_rate_load      (rate_load),
        .i_underrun_clr   (underrun_clr),
        .io_strb          (u_if.master),
        .o_underrun       (underrun),
        .o_underrun_count (underrun_count),
        .o_active         (active),
        .o_debug          (debug)
    );

    // Scoreboard monitor: one expected vector per driven cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_act = {u_if.sample_strobe, active, u_if.hb_strobe,
                       u_if.interpolator_strobe, u_if.fifo_rd, u_if.zero_stuff};
            n_chk++;
            if (mon_act !== mon_exp) begin
                n_err++;
                $display("FAIL strobes t=%0t got {ss,act,hb,is,rd,zs}=%b expected %b",
                         $time, mon_act, mon_exp);
            end
        end
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    // Cycles where the block is not running: all strobes expected low.
    task automatic zero_seg(input int n, input logic fe);
        for (int i = 0; i < n; i++) begin
            u_if.fifo_empty = fe;
            exp_q.push_back(6'b000000);
            @(posedge clk); #1;
        end
    endtask

    // RUN cycles k0..k0+n-1 at rate r with the given inputs held.
    task automatic run_seg(input int r, input int k0, input int n, input logic fe,
                           input logic ld, input logic [7:0] rate, input logic clr);
        for (int i = 0; i < n; i++) begin
            int   k;
            logic hb;
            logic is;
            k = k0 + i;
            u_if.fifo_empty = fe;
            rate_load       = ld;
            interp_rate     = rate;
            underrun_clr    = clr;
            hb = ((k + 1) % r) == 0;
            is = ((k + 1) % (2 * r)) == 0;
            exp_q.push_back({1'b1, 1'b1, hb, is, is & ~fe, is & fe});
            @(posedge clk); #1;
        end
        rate_load    = 1'b0;
        underrun_clr = 1'b0;
    endtask

    task automatic load_rate(input logic [7:0] rate);
        interp_rate = rate;
        rate_load   = 1'b1;
        zero_seg(1, 1'b0);
        rate_load   = 1'b0;
        zero_seg(1, 1'b0);
    endtask

    task automatic stop_run(input int r, input int k);
        enable = 1'b0;
        run_seg(r, k, 1, 1'b0, 1'b0, 8'd0, 1'b0);
        zero_seg(1, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; interp_rate = 8'd0; rate_load = 1'b0;
        underrun_clr = 1'b0; u_if.fifo_empty = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        n_chk++;
        if ({u_if.sample_strobe, active, u_if.hb_strobe, u_if.interpolator_strobe,
             u_if.fifo_rd, u_if.zero_stuff} !== 6'b0) begin
            n_err++; $display("FAIL reset_strobes: got nonzero strobes, expected 0");
        end
        n_chk++;
        if ({underrun, underrun_count} !== 17'd0) begin
            n_err++; $display("FAIL reset_underrun: got %b/%0d expected 0/0", underrun, underrun_count);
        end
        n_chk++;
        if (debug !== 8'h00) begin
            n_err++; $display("FAIL reset_debug: got %h expected 00", debug);
        end
        rst_n = 1'b1;
        zero_seg(1, 1'b0);
        $display("test_reset done");
    endtask

    task automatic test_startup_and_disable();
        load_rate(8'd4);
        enable = 1'b1;
        zero_seg(2, 1'b0);
        run_seg(4, 0, 26, 1'b0, 1'b0, 8'd4, 1'b0);
        n_chk++;
        if (debug !== 8'h82) begin
            n_err++; $display("FAIL run_debug: got %h expected 82", debug);
        end
        stop_run(4, 26);
        n_chk++;
        if (debug !== 8'h00) begin
            n_err++; $display("FAIL disable_debug: got %h expected 00", debug);
        end
        // Re-enable restarts at RUN cycle 0.
        enable = 1'b1;
        zero_seg(2, 1'b0);
        run_seg(4, 0, 8, 1'b0, 1'b0, 8'd4, 1'b0);
        stop_run(4, 8);
        $display("test_startup_and_disable done");
    endtask

    task automatic test_priming();
        enable = 1'b1;
        zero_seg(11, 1'b1);
        n_chk++;
        if (debug[7:6] !== 2'b01) begin
            n_err++; $display("FAIL prime_state: got %b expected 01", debug[7:6]);
        end
        zero_seg(1, 1'b0);
        run_seg(4, 0, 8, 1'b0, 1'b0, 8'd4, 1'b0);
        stop_run(4, 8);
        $display("test_priming done");
    endtask

    task automatic test_underrun();
        load_rate(8'd2);
        enable = 1'b1;
        zero_seg(2, 1'b0);
        run_seg(2, 0, 12, 1'b1, 1'b0, 8'd2, 1'b0);
        run_seg(2, 12, 2, 1'b0, 1'b0, 8'd2, 1'b0);
        n_chk++;
        if ({underrun, underrun_count} !== {1'b1, 16'd3}) begin
            n_err++; $display("FAIL underrun_3: got %b/%0d expected 1/3", underrun, underrun_count);
        end
        run_seg(2, 14, 1, 1'b1, 1'b0, 8'd2, 1'b0);
        run_seg(2, 15, 1, 1'b1, 1'b0, 8'd2, 1'b1);
        n_chk++;
        if ({underrun, underrun_count} !== {1'b1, 16'd1}) begin
            n_err++; $display("FAIL clr_coincident: got %b/%0d expected 1/1", underrun, underrun_count);
        end
        run_seg(2, 16, 1, 1'b0, 1'b0, 8'd2, 1'b1);
        n_chk++;
        if ({underrun, underrun_count} !== 17'd0) begin
            n_err++; $display("FAIL clr_plain: got %b/%0d expected 0/0", underrun, underrun_count);
        end
        stop_run(2, 17);
        $display("test_underrun done");
    endtask

    task automatic test_rate_change();
        load_rate(8'd3);
        enable = 1'b1;
        zero_seg(2, 1'b0);
        run_seg(3, 0, 7, 1'b0, 1'b0, 8'd3, 1'b0);
        run_seg(3, 7, 1, 1'b0, 1'b1, 8'd8, 1'b0);
        n_chk++;
        if (debug[4] !== 1'b1) begin
            n_err++; $display("FAIL pend_set: got %b expected 1", debug[4]);
        end
        run_seg(3, 8, 4, 1'b0, 1'b0, 8'd8, 1'b0);
        n_chk++;
        if (debug[4] !== 1'b0) begin
            n_err++; $display("FAIL pend_clear: got %b expected 0", debug[4]);
        end
        run_seg(8, 0, 31, 1'b0, 1'b0, 8'd8, 1'b0);
        // Load coinciding with a boundary; rate 0 behaves as 1.
        run_seg(8, 31, 1, 1'b0, 1'b1, 8'd0, 1'b0);
        run_seg(1, 0, 6, 1'b0, 1'b0, 8'd0, 1'b0);
        stop_run(1, 6);
        $display("test_rate_change done");
    endtask

    task automatic test_async_reset();
        enable = 1'b1;
        zero_seg(2, 1'b0);
        run_seg(1, 0, 5, 1'b1, 1'b0, 8'd0, 1'b0);
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({u_if.sample_strobe, active, u_if.hb_strobe, u_if.interpolator_strobe,
             u_if.fifo_rd, u_if.zero_stuff} !== 6'b0) begin
            n_err++; $display("FAIL async_strobes: got nonzero strobes, expected 0");
        end
        n_chk++;
        if ({underrun, underrun_count, debug} !== 25'd0) begin
            n_err++; $display("FAIL async_state: got %b/%0d/%h expected 0/0/00",
                              underrun, underrun_count, debug);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; enable = 1'b0;
        zero_seg(1, 1'b0);
        enable = 1'b1;
        zero_seg(2, 1'b0);
        run_seg(1, 0, 4, 1'b0, 1'b0, 8'd0, 1'b0);
        stop_run(1, 4);
        $display("test_async_reset done");
    endtask

    task automatic test_saturation();
        // Preload the counter near full so saturation is reached quickly.
        force dut.r_underrun_count = 16'hFFFC;
        #1;
        release dut.r_underrun_count;
        n_chk++;
        if (underrun_count !== 16'hFFFC) begin
            n_err++; $display("FAIL sat_preload: got %h expected fffc", underrun_count);
        end
        @(posedge clk); #1;
        enable = 1'b1;
        zero_seg(2, 1'b0);
        run_seg(1, 0, 6, 1'b1, 1'b0, 8'd0, 1'b0);
        n_chk++;
        if (underrun_count !== 16'hFFFF) begin
            n_err++; $display("FAIL sat_reach: got %h expected ffff", underrun_count);
        end
        run_seg(1, 6, 6, 1'b1, 1'b0, 8'd0, 1'b0);
        n_chk++;
        if ({underrun, underrun_count} !== {1'b1, 16'hFFFF}) begin
            n_err++; $display("FAIL sat_hold: got %b/%h expected 1/ffff", underrun, underrun_count);
        end
        stop_run(1, 12);
        $display("test_saturation done");
    endtask

    initial begin
        u_if.fifo_empty = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_startup_and_disable();
        test_priming();
        test_underrun();
        test_rate_change();
        test_async_reset();
        test_saturation();
        @(posedge clk); #1;
        n_chk++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/tx_strobe_sched.md
# tx_strobe_sched

Strobe scheduler and sample-fetch controller for the TX interpolation chain. It generates the three rate strobes that sequence the halfband interpolator (×2) and the CIC interpolators (×interp_rate), so that one input sample is consumed every 2·interp_rate clocks. It gates start-up on TX FIFO occupancy and applies rate changes only on input-sample boundaries. It detects and counts FIFO underruns, and forces zero samples into the chain whenever an underrun occurs.

## Interface
- No parameters.
- clock  in  1  master DSP clock (DAC sample rate)
- reset  in  1  asynchronous, active-low; all state cleared while low
- enable  in  1  TX chain enable; low forces IDLE
- interp_rate  in  8  CIC interpolation factor; 0 is treated as 1
- rate_load  in  1  single-cycle pulse; captures interp_rate
- fifo_empty  in  1  TX FIFO has no I/Q sample available
- underrun_clr  in  1  single-cycle pulse; clears underrun and underrun_count
- sample_strobe  out  1  CIC output strobe (DAC rate)
- hb_strobe  out  1  halfband output strobe / CIC input strobe
- interpolator_strobe  out  1  halfband input strobe; one new sample consumed
- fifo_rd  out  1  FIFO pop
- zero_stuff  out  1  datapath must present 0 on i_in/q_in this cycle
- underrun  out  1  sticky underrun flag
- underrun_count  out  16  saturating underrun counter
- active  out  1  high in RUN
- debug  out  8  {state[1:0], hb_phase, pend, cic_cnt[3:0]}

## Operation
- States: IDLE=0, PRIME=1, RUN=2. Encoding 3 is unused and returns to IDLE.
- IDLE → PRIME when enable=1.
- PRIME → RUN on the first cycle with fifo_empty=0.
- Any state → IDLE on the clock edge after enable=0 is sampled. On that edge cic_cnt, hb_phase and the pending-rate flag clear.
- Registers:
  - rate_q (8b): effective rate; reset value 1.
  - rate_pend (8b) and pend (1b): pending rate.
  - cic_cnt (8b).
  - hb_phase (1b).
- On RUN entry, cic_cnt=0 and hb_phase=0.
- Strobes are decoded combinationally from registered state and counters, and are only ever high in RUN:
  - sample_strobe = (state==RUN).
  - hb_strobe = RUN & (cic_cnt == rate_q−1). When it fires, cic_cnt wraps to 0; otherwise cic_cnt increments.
  - hb_phase toggles on every hb_strobe.
  - interpolator_strobe = hb_strobe & hb_phase.
- FIFO handling, evaluated each cycle interpolator_strobe is high:
  - fifo_rd = interpolator_strobe & ~fifo_empty.
  - zero_stuff = interpolator_strobe & fifo_empty.
  - On zero_stuff, underrun sets and underrun_count increments, saturating at 0xFFFF.
  - The state stays in RUN; the schedule is never stalled.
- Rate changes:
  - rate_load captures max(interp_rate,1) into rate_pend and sets pend. If several loads arrive before the next boundary, the last one wins.
  - In IDLE/PRIME, rate_q takes rate_pend on the next edge and pend clears.
  - In RUN, rate_q is updated only on an edge where interpolator_strobe=1; pend clears on that edge.
  - If rate_load coincides with interpolator_strobe, the new interp_rate is applied at that same boundary.
- underrun_clr clears underrun and underrun_count. If it coincides with a new underrun, the result is underrun=1 and underrun_count=1.

## Timing
- Every output is 0 during reset and while in IDLE/PRIME.
- Latency from enable rising to the first sample_strobe: 2 clocks, provided fifo_empty=0 (IDLE→PRIME edge, then PRIME→RUN edge).
- In steady state, with R = rate_q:
  - hb_strobe period = R clocks; first hb_strobe at RUN cycle R−1, counting from 0.
  - interpolator_strobe period = 2R; first one at RUN cycle 2R−1.
- With R=1: hb_strobe is high every RUN cycle and interpolator_strobe every second cycle.
- A rate change takes effect on the edge of the boundary cycle. The next hb_strobe therefore arrives R_new clocks later.
- fifo_rd and zero_stuff are exactly coincident with interpolator_strobe. The FIFO data is consumed on the same clock.
- If reset is asserted mid-RUN, all strobes drop immediately (asynchronous). After release, the block restarts from IDLE.

## Test plan
- Start-up with rate 4: reset released, interp_rate=4, rate_load pulse, enable=1, fifo_empty=0 → first sample_strobe 2 clocks after enable; hb_strobe at RUN cycles 3, 7, 11; interpolator_strobe and fifo_rd at cycles 7, 15, 23.
- Priming: enable=1 with fifo_empty=1 for 10 clocks, then 0 → state stays PRIME, all strobes 0, fifo_rd never asserted; RUN starts on the edge after fifo_empty falls.
- Underrun: in RUN with R=2, fifo_empty=1 across 3 interpolator_strobes → zero_stuff high on those 3 cycles, fifo_rd low, underrun=1, underrun_count=3. A subsequent underrun_clr coincident with a 4th underrun → underrun=1, underrun_count=1.
- Rate changes:
  - rate_load with interp_rate=8 mid-frame while R=3 → period stays 6 until the next interpolator_strobe, then becomes 16.
  - interp_rate=0 → behaves as R=1, interpolator_strobe period 2.
- Disable and reset: enable dropped mid-frame → strobes low from the next clock, state IDLE, cic_cnt=0. Re-enable → schedule restarts at RUN cycle 0. Asynchronous reset mid-RUN → all outputs 0 without waiting for a clock edge.
- Saturation: force 65 540 underruns → underrun_count holds at 0xFFFF.
